com_cmd_arbiter: RTL and testbench

//   Shares the single command channel among N_REQ requesters. Round-robin pick of
//   one pending request; one-cycle Write strobe with that requester's command word;

---
 rtl/com_cmd_arbiter.sv | 140 ++++++++++++++
 tb/tb_com_cmd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_cmd_arbiter.sv
// Round-robin owner of the command channel: one Write strobe per grant, done on ComEnd.
// Optional WAIT-state timeout with err flag when COM_TIMEOUT_EN is defined.
module com_cmd_arbiter #(
  parameter int N_REQ       = 4,
  parameter int CMD_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CMD_W-1:0] cmd_in,
  input  logic                   ComEnd,
  output logic                   Write,
  output logic [CMD_W-1:0]       Cmd,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic [PW:0]     sum;
  logic            found;
  logic [N_REQ-1:0] pick_oh;
  logic [CMD_W-1:0] pick_cmd;

  // Scan upward from ptr, wrapping, for the first pending requester
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    pick_oh  = '0;
    pick_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == pick) begin
        pick_oh[i] = 1'b1;
        pick_cmd   = cmd_in[i*CMD_W +: CMD_W];
      end
    end
  end

`ifdef COM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          tmo;
  assign tmo = (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      Write <= 1'b0;
      Cmd   <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
`ifdef COM_TIMEOUT_EN
      err   <= 1'b0;
      tcnt  <= '0;
`endif
    end else begin
      Write <= 1'b0;
      done  <= '0;
`ifdef COM_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state <= ISSUE;
            owner <= pick;
            grant <= pick_oh;
            Cmd   <= pick_cmd;
            Write <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef COM_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (ComEnd) begin
            state <= DONE;
            done  <= grant;
          end
`ifdef COM_TIMEOUT_EN
          else if (tmo) begin
            state <= DONE;
            done  <= grant;
            err   <= 1'b1;
          end else begin
            tcnt  <= tcnt + TW'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_cmd_arbiter.sv
// Randomized bench for com_cmd_arbiter against a transaction-level
// round-robin model; timeout checks follow COM_TIMEOUT_EN.
module tb_com_cmd_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*W-1:0] cmd_in;
  logic          ComEnd;
  logic          Write;
  logic [W-1:0]  Cmd;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          err;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;
  int cyc      = 0;

  com_cmd_arbiter #(.N_REQ(N), .CMD_W(W), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd_in(cmd_in),
    .ComEnd(ComEnd), .Write(Write), .Cmd(Cmd), .grant(grant),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (Write === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; ComEnd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_reset();
    cmd_in = '0;
    apply_reset();
    checks++;
    if ({Write, Cmd, grant, done, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state got W=%b C=%h g=%b d=%b e=%b b=%b want all 0",
               Write, Cmd, grant, done, err, busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({Write, grant, done, busy} !== '0) begin
        failures++;
        $display("FAIL idle_quiet cyc%0d got W=%b g=%b d=%b b=%b want 0",
                 i, Write, grant, done, busy);
      end
    end
  endtask

  task automatic test_single();
    cmd_in[0*W +: W] = 16'hA5A5;
    req = 4'b0001;
    tick();
    checks++;
    if (Write !== 1'b1 || Cmd !== 16'hA5A5 || grant !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue got W=%b C=%h g=%b b=%b want 1 a5a5 0001 1",
               Write, Cmd, grant, busy);
    end
    req = '0;
    tick(); tick(); tick();
    checks++;
    if (Write !== 1'b0 || grant !== 4'b0001 || done !== '0) begin
      failures++;
      $display("FAIL single_wait got W=%b g=%b d=%b want 0 0001 0000",
               Write, grant, done);
    end
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== 4'b0001 || err !== 1'b0 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL single_done got d=%b e=%b g=%b want 0001 0 0001",
               done, err, grant);
    end
    tick();
    checks++;
    if (done !== '0 || grant !== '0 || busy !== 1'b0 || Cmd !== 16'hA5A5) begin
      failures++;
      $display("FAIL single_idle got d=%b g=%b b=%b C=%h want 0 0 0 a5a5",
               done, grant, busy, Cmd);
    end
    ptr_m = 1;
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp;
    int last;
    last = 0;
    apply_reset();
    for (int i = 0; i < N; i++) cmd_in[i*W +: W] = W'($urandom);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_write(20, ok);
      exp = rr_pick(4'b1111, ptr_m);
      checks++;
      if (!ok || grant !== oh(exp) || Cmd !== cmd_in[exp*W +: W]) begin
        failures++;
        $display("FAIL rr_grant%0d got ok=%0d g=%b C=%h want g=%b C=%h",
                 g, ok, grant, Cmd, oh(exp), cmd_in[exp*W +: W]);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last != 5) begin
          failures++;
          $display("FAIL rr_gap%0d got %0d want 5", g, cyc - last);
        end
      end
      last = cyc;
      tick(); tick();
      ComEnd = 1'b1;
      tick();
      ComEnd = 1'b0;
      checks++;
      if (done !== oh(exp)) begin
        failures++;
        $display("FAIL rr_done%0d got %b want %b", g, done, oh(exp));
      end
      ptr_m = (exp + 1) % N;
    end
    req = '0;
    tick();
  endtask

  task automatic test_comend_ignored();
    int exp;
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_comend got d=%b b=%b want 0 0", done, busy);
    end
    cmd_in[1*W +: W] = W'($urandom);
    req = 4'b0010;
    exp = rr_pick(req, ptr_m);
    tick();
    checks++;
    if (Write !== 1'b1 || grant !== oh(exp)) begin
      failures++;
      $display("FAIL ign_issue got W=%b g=%b want 1 %b", Write, grant, oh(exp));
    end
    ComEnd = 1'b1;
    req = '0;
    tick();
    ComEnd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== '0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL ign_wait%0d got d=%b b=%b want 0000 1", i, done, busy);
      end
    end
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== oh(exp)) begin
      failures++;
      $display("FAIL ign_done got %b want %b", done, oh(exp));
    end
    ptr_m = (exp + 1) % N;
    tick();
  endtask

  task automatic test_reset_mid();
    int exp;
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre got g=%b b=%b want 0100 1", grant, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_m = 0;
    checks++;
    if ({Write, Cmd, grant, done, err, busy} !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear got W=%b C=%h g=%b d=%b e=%b b=%b want 0",
               Write, Cmd, grant, done, err, busy);
    end
    req = 4'b0110;
    exp = rr_pick(req, ptr_m);
    tick();
    req = '0;
    checks++;
    if (grant !== oh(exp) || Write !== 1'b1 || exp != 1) begin
      failures++;
      $display("FAIL rst_mid_win got g=%b W=%b want %b 1", grant, Write, oh(exp));
    end
    tick();
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== oh(exp)) begin
      failures++;
      $display("FAIL rst_mid_done got %b want %b", done, oh(exp));
    end
    ptr_m = (exp + 1) % N;
    tick();
  endtask

  task automatic test_random();
    int exp;
    int d;
    logic [N-1:0] r;
    logic [W-1:0] word;
    for (int it = 0; it < 40; it++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) cmd_in[i*W +: W] = W'($urandom);
      req = r;
      exp = rr_pick(r, ptr_m);
      word = cmd_in[exp*W +: W];
      d = $urandom_range(0, 3);
      tick();
      checks++;
      if (Write !== 1'b1 || grant !== oh(exp) || Cmd !== word || busy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_issue%0d got W=%b g=%b C=%h want 1 %b %h",
                 it, Write, grant, Cmd, oh(exp), word);
      end
      req = N'($urandom);
      cmd_in = {$urandom, $urandom};
      tick();
      for (int k = 0; k < d; k++) tick();
      checks++;
      if (Write !== 1'b0 || Cmd !== word || done !== '0 || grant !== oh(exp)) begin
        failures++;
        $display("FAIL rnd_wait%0d got W=%b C=%h d=%b g=%b want 0 %h 0 %b",
                 it, Write, Cmd, done, grant, word, oh(exp));
      end
      ComEnd = 1'b1;
      tick();
      ComEnd = 1'b0;
      req = '0;
      checks++;
      if (done !== oh(exp) || err !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_done%0d got d=%b e=%b b=%b want %b 0 1",
                 it, done, err, busy, oh(exp));
      end
      ptr_m = (exp + 1) % N;
      tick();
      checks++;
      if (done !== '0 || grant !== '0 || busy !== 1'b0 || Cmd !== word) begin
        failures++;
        $display("FAIL rnd_idle%0d got d=%b g=%b b=%b C=%h want 0 0 0 %h",
                 it, done, grant, busy, Cmd, word);
      end
    end
  endtask

  task automatic test_timeout();
    int exp;
    bit early;
    req = 4'b1000;
    exp = rr_pick(req, ptr_m);
    tick();
    req = '0;
    tick();
`ifdef COM_TIMEOUT_EN
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done !== '0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL tmo_early got done before limit want none");
    end
    tick();
    checks++;
    if (done !== oh(exp) || err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_fire got d=%b e=%b want %b 1", done, err, oh(exp));
    end
    ptr_m = (exp + 1) % N;
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_idle got e=%b b=%b want 0 0", err, busy);
    end
    req = 4'b0001;
    exp = rr_pick(req, ptr_m);
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== oh(exp) || err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_tie got d=%b e=%b want %b 0", done, err, oh(exp));
    end
`else
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || done !== '0 || err !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL no_tmo_hold got busy dropped or done/err seen want busy held");
    end
    ComEnd = 1'b1;
    tick();
    ComEnd = 1'b0;
    checks++;
    if (done !== oh(exp) || err !== 1'b0) begin
      failures++;
      $display("FAIL no_tmo_done got d=%b e=%b want %b 0", done, err, oh(exp));
    end
`endif
    ptr_m = (exp + 1) % N;
    tick();
  endtask

  initial begin
    reset = 1'b1; req = '0; ComEnd = 1'b0; cmd_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_comend_ignored();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
